// File: rtl/vtg_pkg.sv
// Shared 1080p60 timing constants, lock FSM state encoding and colour-bar palette
// for the video timing generator. Optional build macro: VTG_PATTERN_EN.
package vtg_pkg;

  localparam int VTG_H_ACTIVE    = 1920;
  localparam int VTG_H_FP        = 88;
  localparam int VTG_H_SYNC      = 44;
  localparam int VTG_H_BP        = 148;
  localparam int VTG_V_ACTIVE    = 1080;
  localparam int VTG_V_FP        = 4;
  localparam int VTG_V_SYNC      = 5;
  localparam int VTG_V_BP        = 36;
  localparam logic VTG_HS_POL    = 1'b1;
  localparam logic VTG_VS_POL    = 1'b1;
  localparam int VTG_LOCK_SETTLE = 1024;
  localparam int VTG_BAR_WIDTH   = 240;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } vtg_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Eight vertical bars across the active width, left to right.
  function automatic logic [23:0] bar_color(input logic [11:0] col);
    logic [23:0] c;
    case (int'(col) / VTG_BAR_WIDTH)
      0:       c = BAR_WHITE;
      1:       c = BAR_YELLOW;
      2:       c = BAR_CYAN;
      3:       c = BAR_GREEN;
      4:       c = BAR_MAGENTA;
      5:       c = BAR_RED;
      6:       c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_lock_ctrl.sv
// PLL-lock gating: 2-flop synchroniser, settle counter and WAIT_LOCK/SETTLE/RUN FSM.
// run is high while the FSM sits in RUN; state is exposed for debug.
module vtg_lock_ctrl
  import vtg_pkg::*;
#(
  parameter int LOCK_SETTLE = VTG_LOCK_SETTLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       run,
  output vtg_state_e state
);

  localparam int CW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_SETTLE - 1);

  logic [1:0]  sync_q;
  logic        locked_s;
  logic [CW-1:0] cnt_q, cnt_d;
  vtg_state_e  state_q, state_d;

  assign locked_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      state_q <= WAIT_LOCK;
    end else begin
      sync_q  <= {sync_q[0], locked};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Losing lock in SETTLE or RUN always falls straight back to WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign run   = (state_q == RUN);
  assign state = state_q;

endmodule

// File: rtl/video_timing_gen.sv
// 1080p60 HS/VS/DE/x/y generator gated by PLL lock; all outputs registered one cycle
// after the h/v counters. VTG_PATTERN_EN selects internal colour bars over rgb_in.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE    = VTG_H_ACTIVE,
  parameter int   H_FP        = VTG_H_FP,
  parameter int   H_SYNC      = VTG_H_SYNC,
  parameter int   H_BP        = VTG_H_BP,
  parameter int   V_ACTIVE    = VTG_V_ACTIVE,
  parameter int   V_FP        = VTG_V_FP,
  parameter int   V_SYNC      = VTG_V_SYNC,
  parameter int   V_BP        = VTG_V_BP,
  parameter logic HS_POL      = VTG_HS_POL,
  parameter logic VS_POL      = VTG_VS_POL,
  parameter int   LOCK_SETTLE = VTG_LOCK_SETTLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        locked,
  input  logic [23:0] rgb_in,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic [23:0] rgb_out,
  output logic        running,
  output vtg_state_e  fsm_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic        run;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_act, v_act, h_sync, v_sync, de_d;
  logic [23:0] pix_d;

  vtg_lock_ctrl #(.LOCK_SETTLE(LOCK_SETTLE)) u_lock_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .locked (locked),
    .run    (run),
    .state  (fsm_state)
  );

  assign running = run;

  // Counters sit at 0 outside RUN so the first RUN cycle is (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 12'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 11'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    h_act  = (h_cnt < 12'(H_ACTIVE));
    v_act  = (v_cnt < 11'(V_ACTIVE));
    h_sync = (h_cnt >= 12'(H_ACTIVE + H_FP)) && (h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC));
    v_sync = (v_cnt >= 11'(V_ACTIVE + V_FP)) && (v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC));
    de_d   = run && h_act && v_act;
  end

`ifdef VTG_PATTERN_EN
  logic unused_rgb_in;
  assign unused_rgb_in = ^rgb_in;
  assign pix_d = bar_color(h_cnt);
`else
  assign pix_d = rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      hs          <= h_sync ? HS_POL : ~HS_POL;
      vs          <= v_sync ? VS_POL : ~VS_POL;
      de          <= de_d;
      x           <= de_d ? h_cnt : '0;
      y           <= de_d ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      rgb_out     <= de_d ? pix_d : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a shortened frame (13 lines) and LOCK_SETTLE=16:
// phase table + per-cycle scoreboard queue + hand-written spot and lock-loss sequences.
module tb_video_timing_gen;
  import vtg_pkg::*;

  localparam int LS    = 16;
  localparam int VA    = 8;
  localparam int VFP   = 1;
  localparam int VSY   = 2;
  localparam int VBP   = 2;
  localparam int HT    = 2200;
  localparam int VT    = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int INF   = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst_n, locked;
  logic [23:0] rgb_in;
  logic        hs, vs, de, frame_start, running;
  logic [11:0] x;
  logic [10:0] y;
  logic [23:0] rgb_out;
  vtg_state_e  fsm_state;

  always #5 clk = ~clk;

  video_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .LOCK_SETTLE(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .rgb_in(rgb_in),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .frame_start(frame_start),
    .rgb_out(rgb_out), .running(running), .fsm_state(fsm_state)
  );

  typedef struct packed {
    int          t;
    logic        running;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    string name;
    logic  rst_v;
    logic  lock_v;
    int    cycles;
  } phase_t;

  typedef struct {
    string name;
    int    t;
    logic  de, hs, vs, fs;
    int    x, y;
  } spot_t;

  typedef struct {
    string       name;
    int          t;
    logic [23:0] rgb;
  } rgb_spot_t;

  exp_t        exp_q[$];
  phase_t      phases[3];
  spot_t       spots[18];
  rgb_spot_t   rgb_spots[3];
  logic [23:0] bars[8];
  int          fs_edges[$];

  int   checks = 0, failures = 0;
  int   ec = 0;
  int   run_from = INF, run_until = INF;
  logic prev_rst = 1'b0, prev_lock = 1'b0;
  logic first_run = 1'b1;
  int   de_cnt = 0, vs_cnt = 0, hs_cnt = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int e, input logic rst_v, input logic [23:0] rgb_v);
    exp_t r;
    int   t, h, v;
    r   = '0;
    r.t = -1;
    if (rst_v) begin
      r.running = (e >= run_from) && (e < run_until);
      if ((e - 1 >= run_from) && (e - 1 < run_until)) begin
        t    = e - 1 - run_from;
        h    = t % HT;
        v    = (t / HT) % VT;
        r.t  = t;
        r.hs = (h >= 2008) && (h < 2052);
        r.vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
        r.de = (h < 1920) && (v < VA);
        r.fs = (h == 0) && (v == 0);
        if (r.de) begin
          r.x = 12'(h);
          r.y = 11'(v);
`ifdef VTG_PATTERN_EN
          r.rgb = bars[h / 240];
`else
          r.rgb = rgb_v;
`endif
        end
      end
    end
    return r;
  endfunction

  // One clock: drive inputs, queue the expected post-edge outputs, then compare.
  task automatic cycle(input logic rst_v, input logic lock_v);
    int          e, tn;
    logic [23:0] rgb_v;
    exp_t        ex, act;
    e = ec + 1;
    if (!rst_v) begin
      run_from  = INF;
      run_until = INF;
    end else if (lock_v && !(prev_rst && prev_lock)) begin
      run_from  = e + LS + 2;
      run_until = INF;
    end else if (!lock_v && prev_rst && prev_lock) begin
      run_until = e + 2;
    end
    tn    = (rst_v && (e - 1 >= run_from) && (e - 1 < run_until)) ? e - 1 - run_from : -1;
    rgb_v = (tn >= 0 && tn < 4) ? 24'h123456 : 24'($urandom);
    exp_q.push_back(model(e, rst_v, rgb_v));
    rst_n     = rst_v;
    locked    = lock_v;
    rgb_in    = rgb_v;
    prev_rst  = rst_v;
    prev_lock = lock_v;
    ec        = e;
    @(posedge clk);
    @(negedge clk);
    ex          = exp_q.pop_front();
    act         = '0;
    act.t       = ex.t;
    act.running = running;
    act.hs      = hs;
    act.vs      = vs;
    act.de      = de;
    act.fs      = frame_start;
    act.x       = x;
    act.y       = y;
    act.rgb     = rgb_out;
    checks++;
    if (act !== ex) begin
      failures++;
      if (failures <= 40)
        $display("FAIL sb e=%0d t=%0d actual run=%b hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h required run=%b hs=%b vs=%b de=%b fs=%b x=%0d y=%0d rgb=%h",
                 e, ex.t, act.running, act.hs, act.vs, act.de, act.fs, act.x, act.y, act.rgb,
                 ex.running, ex.hs, ex.vs, ex.de, ex.fs, ex.x, ex.y, ex.rgb);
    end
    for (int i = 0; i < 18; i++) begin
      if (ex.t == spots[i].t) begin
        check_eq({spots[i].name, "_de"}, 64'(de), 64'(spots[i].de));
        check_eq({spots[i].name, "_hs"}, 64'(hs), 64'(spots[i].hs));
        check_eq({spots[i].name, "_vs"}, 64'(vs), 64'(spots[i].vs));
        check_eq({spots[i].name, "_fs"}, 64'(frame_start), 64'(spots[i].fs));
        check_eq({spots[i].name, "_x"}, 64'(x), 64'(spots[i].x));
        check_eq({spots[i].name, "_y"}, 64'(y), 64'(spots[i].y));
      end
    end
    for (int i = 0; i < 3; i++)
      if (ex.t == rgb_spots[i].t) check_eq(rgb_spots[i].name, 64'(rgb_out), 64'(rgb_spots[i].rgb));
    if (first_run && ex.t >= 0 && ex.t < FRAME) begin
      if (de === 1'b1) de_cnt++;
      if (vs === 1'b1) vs_cnt++;
      if (hs === 1'b1) hs_cnt++;
    end
    if (first_run && frame_start === 1'b1) fs_edges.push_back(e);
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    phases[0] = '{"reset",  1'b0, 1'b1, 5};
    phases[1] = '{"settle", 1'b1, 1'b1, LS + 2};
    phases[2] = '{"frame",  1'b1, 1'b1, 30998};

    spots[0]  = '{"first_px",    0,     1'b1, 1'b0, 1'b0, 1'b1, 0,    0};
    spots[1]  = '{"second_px",   1,     1'b1, 1'b0, 1'b0, 1'b0, 1,    0};
    spots[2]  = '{"last_act",    1919,  1'b1, 1'b0, 1'b0, 1'b0, 1919, 0};
    spots[3]  = '{"first_blank", 1920,  1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[4]  = '{"pre_hs",      2007,  1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[5]  = '{"hs_first",    2008,  1'b0, 1'b1, 1'b0, 1'b0, 0,    0};
    spots[6]  = '{"hs_last",     2051,  1'b0, 1'b1, 1'b0, 1'b0, 0,    0};
    spots[7]  = '{"hs_end",      2052,  1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[8]  = '{"line_end",    2199,  1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[9]  = '{"line1_px0",   2200,  1'b1, 1'b0, 1'b0, 1'b0, 0,    1};
    spots[10] = '{"last_px",     17319, 1'b1, 1'b0, 1'b0, 1'b0, 1919, 7};
    spots[11] = '{"vblank",      17600, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[12] = '{"pre_vs",      19799, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[13] = '{"vs_first",    19800, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0};
    spots[14] = '{"vs_hs",       21808, 1'b0, 1'b1, 1'b1, 1'b0, 0,    0};
    spots[15] = '{"vs_last",     24199, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0};
    spots[16] = '{"vs_end",      24200, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
    spots[17] = '{"frame2",      28600, 1'b1, 1'b0, 1'b0, 1'b1, 0,    0};

`ifdef VTG_PATTERN_EN
    rgb_spots[0] = '{"bar_x0",    0,    24'hFFFFFF};
    rgb_spots[1] = '{"bar_x240",  240,  24'hFFFF00};
    rgb_spots[2] = '{"bar_x1919", 1919, 24'h000000};
`else
    rgb_spots[0] = '{"rgb_pass",  2,    24'h123456};
    rgb_spots[1] = '{"rgb_pass3", 3,    24'h123456};
    rgb_spots[2] = '{"rgb_blank", 1920, 24'h000000};
`endif

    rst_n  = 1'b0;
    locked = 1'b1;
    rgb_in = '0;

    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < phases[p].cycles; c++) cycle(phases[p].rst_v, phases[p].lock_v);
      if (p == 1) begin
        check_eq("settle_running_lo", 64'(running), 64'd0);
        cycle(1'b1, 1'b1);
        check_eq("settle_running_hi", 64'(running), 64'd1);
        check_eq("settle_de_lo", 64'(de), 64'd0);
        cycle(1'b1, 1'b1);
        check_eq("start_de", 64'(de), 64'd1);
        check_eq("start_fs", 64'(frame_start), 64'd1);
      end
    end

    check_eq("frame_de_cycles", 64'(de_cnt), 64'(VA * 1920));
    check_eq("frame_vs_cycles", 64'(vs_cnt), 64'(VSY * HT));
    check_eq("frame_hs_cycles", 64'(hs_cnt), 64'(VT * 44));
    check_eq("fs_count", 64'(fs_edges.size()), 64'd2);
    if (fs_edges.size() >= 2) check_eq("fs_period", 64'(fs_edges[1] - fs_edges[0]), 64'(FRAME));
    first_run = 1'b0;

    // Lock loss mid-line (line 1 of frame 2, active area).
    check_eq("pre_drop_de", 64'(de), 64'd1);
    repeat (3) cycle(1'b1, 1'b0);
    check_eq("drop_running", 64'(running), 64'd0);
    cycle(1'b1, 1'b0);
    check_eq("drop_de", 64'(de), 64'd0);
    check_eq("drop_hs", 64'(hs), 64'd0);
    check_eq("drop_vs", 64'(vs), 64'd0);
    repeat (36) cycle(1'b1, 1'b0);

    repeat (LS + 3) cycle(1'b1, 1'b1);
    check_eq("relock_running", 64'(running), 64'd1);
    cycle(1'b1, 1'b1);
    check_eq("relock_de", 64'(de), 64'd1);
    check_eq("relock_fs", 64'(frame_start), 64'd1);
    check_eq("relock_x", 64'(x), 64'd0);
    check_eq("relock_y", 64'(y), 64'd0);
    repeat (2300) cycle(1'b1, 1'b1);

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
